// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I funct3 codes,
// FSM states and the default bus timeout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [3:0]  wea;
  logic [31:0] Data_in;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, Addr_out, Data_out, wea,
    input  Data_in, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, Addr_out, Data_out, wea,
    output Data_in, bus_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: access legality, store steering/byte enables,
// and load extraction with sign/zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic        st_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  output logic        legal_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wea_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    legal_o = 1'b0;
    unique case (funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_BU:   legal_o = !st_i;
      F3_H:    legal_o = !off_i[0];
      F3_HU:   legal_o = !st_i && !off_i[0];
      F3_W:    legal_o = (off_i == 2'b00);
      default: legal_o = 1'b0;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    wea_o   = '0;
    if (st_i) begin
      unique case (funct3_i)
        F3_B: begin
          wdata_o = {4{rs2_i[7:0]}};
          wea_o   = 4'b0001 << off_i;
        end
        F3_H: begin
          wdata_o = {2{rs2_i[15:0]}};
          wea_o   = 4'b0011 << {off_i[1], 1'b0};
        end
        F3_W: begin
          wdata_o = rs2_i;
          wea_o   = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ldata_o = '0;
    unique case (ld_funct3_i)
      F3_B:    ldata_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ldata_o = {24'h0, ld_byte};
      F3_H:    ldata_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ldata_o = {16'h0, ld_half};
      F3_W:    ldata_o = rdata_i;
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack bus FSM with pipeline stall and error pulse.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid_MEM,
  input  logic                      MemRW_MEM,
  input  logic [2:0]                funct3_MEM,
  input  logic [31:0]               ALUO_MEM,
  input  logic [31:0]               Dataout_MEM,
  mem_access_unit_if.master         bus,
  output logic [31:0]               Datai,
  output logic                      mem_stall,
  output logic                      mem_err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wea_q, wea_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] datai_q, datai_d;
  logic        err_q, err_d;

  logic        legal;
  logic [31:0] st_wdata;
  logic [3:0]  st_wea;
  logic [31:0] ld_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  lsu_align u_align (
    .st_i        (MemRW_MEM),
    .funct3_i    (funct3_MEM),
    .off_i       (ALUO_MEM[1:0]),
    .rs2_i       (Dataout_MEM),
    .legal_o     (legal),
    .wdata_o     (st_wdata),
    .wea_o       (st_wea),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (bus.Data_in),
    .ldata_o     (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wea_d     = wea_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    datai_d   = datai_q;
    err_d     = err_q;
    mem_stall = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        mem_stall = mem_valid_MEM;
        if (mem_valid_MEM) begin
          if (legal) begin
            addr_d  = {ALUO_MEM[31:2], 2'b00};
            wdata_d = st_wdata;
            wea_d   = st_wea;
            we_d    = MemRW_MEM;
            f3_d    = funct3_MEM;
            off_d   = ALUO_MEM[1:0];
            err_d   = 1'b0;
            state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            datai_d = '0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (bus.bus_ack) begin
          datai_d = we_q ? 32'h0 : ld_data;
          err_d   = 1'b0;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // An ack in the timeout cycle takes priority and completes normally.
        else if (timeout) begin
          datai_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // A still-high mem_valid_MEM here is the same instruction; never re-issue.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wea_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      datai_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wea_q   <= wea_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      datai_q <= datai_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.bus_req  = (state_q == BUSY);
  assign bus.bus_we   = we_q;
  assign bus.Addr_out = addr_q;
  assign bus.Data_out = wdata_q;
  assign bus.wea      = wea_q;
  assign Datai        = datai_q;
  assign mem_err      = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses against a behavioural load/store model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_MEM;
  logic        MemRW_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] ALUO_MEM;
  logic [31:0] Dataout_MEM;
  logic [31:0] Datai;
  logic        mem_stall;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid_MEM (mem_valid_MEM),
    .MemRW_MEM     (MemRW_MEM),
    .funct3_MEM    (funct3_MEM),
    .ALUO_MEM      (ALUO_MEM),
    .Dataout_MEM   (Dataout_MEM),
    .bus           (bus_if),
    .Datai         (Datai),
    .mem_stall     (mem_stall),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    if (st) return (f3 inside {3'd0, 3'd1, 3'd2}) && (a % size == 0);
    return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (a % size == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] w;
    byte         sb;
    shortint     sh;
    w  = rdata >> (8 * (a % 4));
    sb = w[7:0];
    sh = w[15:0];
    case (f3)
      3'd0:    return 32'(int'(sb));
      3'd4:    return w & 32'hFF;
      3'd1:    return 32'(int'(sh));
      3'd5:    return w & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] m_wea(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'd0:    return (rs2 & 32'hFF) * 32'h01010101;
      3'd1:    return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  // One complete access starting at a negedge with the unit in IDLE.
  // waits = number of BUSY cycles without ack before the ack cycle.
  task automatic access(input string tag, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int waits);
    bit          legal, to_exp, done, early_err;
    int          stall_n, busy_n, exp_busy;
    logic [31:0] exp_datai;
    legal  = m_legal(st, f3, a);
    to_exp = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to_exp = legal && (waits >= TO);
`endif
    exp_busy  = !legal ? 0 : (to_exp ? TO : waits + 1);
    exp_datai = (!legal || st || to_exp) ? 32'h0 : m_load(f3, a, rdata);
    stall_n   = 0;
    busy_n    = 0;
    done      = 1'b0;
    early_err = 1'b0;

    mem_valid_MEM  = 1'b1;
    MemRW_MEM      = st;
    funct3_MEM     = f3;
    ALUO_MEM       = a;
    Dataout_MEM    = rs2;
    bus_if.Data_in = rdata;
    bus_if.bus_ack = 1'b0;

    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (mem_stall) stall_n++;
      if (bus_if.bus_req) begin
        busy_n++;
        if (busy_n == 1) begin
          check({tag, ".addr"}, bus_if.Addr_out, a & 32'hFFFF_FFFC);
          check({tag, ".we"}, 32'(bus_if.bus_we), 32'(st));
          check({tag, ".wea"}, 32'(bus_if.wea), st ? 32'(m_wea(f3, a)) : 32'h0);
          if (st) check({tag, ".wdata"}, bus_if.Data_out, m_wdata(f3, rs2));
        end
      end
      if (mem_stall && mem_err) early_err = 1'b1;
      if (!mem_stall) begin
        done = 1'b1;
        check({tag, ".err"}, 32'(mem_err), 32'(!legal || to_exp));
        check({tag, ".datai"}, Datai, exp_datai);
        bus_if.bus_ack = 1'b0;
      end else begin
        bus_if.bus_ack = bus_if.bus_req && (busy_n - 1 == waits);
      end
      @(negedge clk);
    end
    mem_valid_MEM  = 1'b0;
    bus_if.bus_ack = 1'b0;
    check({tag, ".completed"}, 32'(done), 32'd1);
    check({tag, ".stall_cycles"}, 32'(stall_n), 32'(legal ? exp_busy + 1 : 1));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, ".early_err"}, 32'(early_err), 32'd0);
    #1;
    check({tag, ".idle_after"}, 32'({bus_if.bus_req, mem_stall, mem_err}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    mem_valid_MEM  = 1'b0;
    MemRW_MEM      = 1'b0;
    funct3_MEM     = 3'd0;
    ALUO_MEM       = '0;
    Dataout_MEM    = '0;
    bus_if.Data_in = '0;
    bus_if.bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.bus_req", 32'(bus_if.bus_req), 32'd0);
    check("reset.bus_we", 32'(bus_if.bus_we), 32'd0);
    check("reset.addr", bus_if.Addr_out, 32'h0);
    check("reset.wdata", bus_if.Data_out, 32'h0);
    check("reset.wea", 32'(bus_if.wea), 32'h0);
    check("reset.datai", Datai, 32'h0);
    check("reset.stall", 32'(mem_stall), 32'd0);
    check("reset.err", 32'(mem_err), 32'd0);
    @(negedge clk);

    access("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 3);
    access("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1);
    access("sh_102", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0);
    access("lw_101", 1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    access("sb_bu_ill", 1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 0);
    access("lh_odd_ill", 1'b0, 3'b001, 32'h301, 32'h0, 32'hAAAA5555, 0);

    // Reset while BUSY: bus_req drops, the late ack is ignored.
    access("lw_pre", 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0);
    mem_valid_MEM  = 1'b1;
    MemRW_MEM      = 1'b0;
    funct3_MEM     = 3'b010;
    ALUO_MEM       = 32'h500;
    bus_if.Data_in = 32'h13572468;
    @(negedge clk);
    #1;
    check("rstbusy.req_before", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    mem_valid_MEM  = 1'b0;
    bus_if.bus_ack = 1'b1;
    #1;
    check("rstbusy.req_after", 32'(bus_if.bus_req), 32'd0);
    check("rstbusy.datai", Datai, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstbusy.ack_ignored_req", 32'(bus_if.bus_req), 32'd0);
    check("rstbusy.ack_ignored_stall", 32'(mem_stall), 32'd0);
    check("rstbusy.ack_ignored_datai", Datai, 32'h0);
    bus_if.bus_ack = 1'b0;
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    access("timeout_lw", 1'b0, 3'b010, 32'h600, 32'h0, 32'hFFFFFFFF, 1000);
    access("ack_at_timeout", 1'b0, 3'b000, 32'h601, 32'h0, 32'h0000_8100, TO - 1);
`else
    begin
      int stall_n;
      int req_n;
      int err_n;
      stall_n = 0;
      req_n   = 0;
      err_n   = 0;
      mem_valid_MEM = 1'b1;
      MemRW_MEM     = 1'b0;
      funct3_MEM    = 3'b010;
      ALUO_MEM      = 32'h600;
      for (int i = 0; i < 24; i++) begin
        #1;
        stall_n += int'(mem_stall);
        req_n   += int'(bus_if.bus_req);
        err_n   += int'(mem_err);
        @(negedge clk);
      end
      check("noack.stall_cycles", 32'(stall_n), 32'd24);
      check("noack.req_cycles", 32'(req_n), 32'd23);
      check("noack.err", 32'(err_n), 32'd0);
      mem_valid_MEM = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
`endif

    for (int n = 0; n < 40; n++) begin
      access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, TO - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB latch.
- Takes the effective address and store data, then runs a req/ack handshake with the data bus.
- Performs byte-lane steering and byte enables for stores, and sign/zero extension for loads.
- Returns the aligned load word as Datai, and holds the pipeline through mem_stall until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of BUSY cycles waiting for bus_ack. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- mem_valid_MEM  in  1  instruction in MEM is a load or store
- MemRW_MEM  in  1  1 = store, 0 = load
- funct3_MEM  in  3  access size and signedness, RV32I encoding
- ALUO_MEM  in  32  effective address
- Dataout_MEM  in  32  store data (rs2)
- Data_in  in  32  bus read data
- bus_ack  in  1  bus completion strobe
- bus_req  out  1  bus request
- bus_we  out  1  bus write strobe
- Addr_out  out  32  bus address, word-aligned ({addr[31:2],2'b00})
- Data_out  out  32  lane-replicated store data
- wea  out  4  byte enables
- Datai  out  32  extended load data to the MEM/WB latch
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; deassert the MEM/WB EN
- mem_err  out  1  one-cycle pulse on a misaligned or illegal access (or a timeout)

Behaviour:
- Reset (synchronous, active-high): all outputs and registers are 0, and the FSM enters IDLE. A reset asserted mid-access drops bus_req in the next cycle, and the pending access is abandoned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_stall = mem_valid_MEM (combinational).
  - When mem_valid_MEM=1 and the access is legal, the unit registers Addr_out, Data_out, wea, bus_we=MemRW_MEM, funct3 and addr[1:0], then moves to BUSY.
  - When mem_valid_MEM=1 and the access is illegal, it moves to DONE with the error flag set.
  - bus_ack is ignored in IDLE.
- BUSY:
  - bus_req=1 and mem_stall=1.
  - On bus_ack=1: Datai is registered from the extended Data_in (loads) or set to 0 (stores). bus_req drops next cycle, and the FSM moves to DONE.
- DONE:
  - mem_stall=0, so the pipeline and the MEM/WB latch advance at the end of this cycle.
  - mem_err=1 if the access was illegal.
  - Next state is always IDLE. A still-high mem_valid_MEM in DONE belongs to the same instruction and is never re-issued.
- Minimum latency: accept cycle N, bus_req during N+1, ack at N+1, DONE at N+2. The pipeline therefore stalls for 2 cycles. Each extra wait cycle adds one stall cycle.
- Legality:
  - funct3 000 / 100: any address.
  - funct3 001 / 101: addr[0]=0.
  - funct3 010: addr[1:0]=0.
  - Stores accept only 000, 001 and 010.
  - Every other funct3 is illegal.
- Store lane steering:
  - sb: Data_out={4{rs2[7:0]}}, wea=4'b0001<<addr[1:0].
  - sh: Data_out={2{rs2[15:0]}}, wea=4'b0011<<{addr[1],1'b0}.
  - sw: Data_out=rs2, wea=4'b1111.
  - Loads: wea=0.
- Load extraction: select the byte or halfword at addr[1:0]. lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- Illegal access: no bus activity and Datai=0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter resets on entry to BUSY.
  - When the counter reaches TIMEOUT_CYCLES without bus_ack, the FSM moves to DONE with mem_err=1, Datai=0 and bus_req dropped.
  - A bus_ack arriving in the same cycle as the timeout wins, and the access completes normally.
- Undefined: there is no counter, and BUSY waits indefinitely.

Decomposition:
- Shared package mem_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, BUSY, DONE);
  - the default TIMEOUT_CYCLES.
- One combinational sub-module, lsu_align, handles store lane steering, wea generation, load extraction/extension and the legality check. The FSM and registers stay in mem_access_unit.

Test Plan:
- sw at addr 0x100, rs2=0xDEADBEEF, ack one cycle after bus_req -> Addr_out=0x100, wea=1111, Data_out=0xDEADBEEF, bus_we=1, mem_stall high 2 cycles, mem_err=0.
- lb at 0x103, Data_in=0x80FF1234, ack after 3 wait cycles -> Datai=0xFFFFFF80, mem_stall high 5 cycles.
- lhu at 0x102, Data_in=0x80FF1234 -> Datai=0x000080FF. sh at 0x102, rs2=0x0000ABCD -> Data_out=0xABCDABCD, wea=1100.
- lw at 0x101 -> no bus_req, mem_err pulse in DONE, Datai=0, stall 1 cycle.
- rst asserted while in BUSY, then ack arrives -> bus_req=0 the next cycle, ack ignored, FSM in IDLE, Datai=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_err pulse after 4 BUSY cycles and bus_req=0. Without the macro, stall persists.
